read_responder: RTL and testbench
=================================

# read_responder

Memory-side responder for the single-master `rd`/`ws`/`ds` read handshake. It samples the initiator's `rd` strobe and captures the address. It then holds `ws` high for a fixed number of wait states, presents the addressed word from an internal register-file memory, and holds it until the initiator's `ds` completion strobe. A side write port loads the memory. The block sits opposite the read-control FSM on the same bus.

## Interface
- `ADDR_W`, 4, address width; memory depth 2^ADDR_W.
- `DATA_W`, 8, data word width.
- `WAIT_CYCLES`, 2, number of cycles `ws` stays high per read; legal 0..15.
- `TIMEOUT`, 16, DATA-state cycles to wait for `ds` when timeout is compiled in; legal 1..255.

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rd` in 1: read request from initiator.
- `addr` in ADDR_W: read address, sampled with `rd`.
- `ds` in 1: initiator done strobe; ends the transfer.
- `we` in 1: memory write enable.
- `waddr` in ADDR_W: write address.
- `wdata` in DATA_W: write data.
- `ws` out 1: wait state; initiator must not take data while high.
- `rdata` out DATA_W: read data, valid while `rvalid`=1.
- `rvalid` out 1: read data valid.
- `err` out 1: one-cycle timeout pulse.

## Operation
- States: IDLE, WAIT, DATA.
- IDLE: `ws`=0, `rvalid`=0. When `rd`=1 at a clock edge, capture `addr` into `addr_q` and load the wait counter with WAIT_CYCLES.
  - If WAIT_CYCLES>0, go to WAIT.
  - Otherwise go directly to DATA.
  - `ds` is ignored in IDLE.
- WAIT: `ws`=1. The counter decrements each cycle. When it reaches 0, go to DATA. `rd` is ignored in WAIT; the initiator's repeated READ cycles do not restart the count. `addr` is ignored.
- DATA: `ws`=0, `rvalid`=1, `rdata`=mem[`addr_q`], registered on entry to DATA. `rdata` holds constant for the whole DATA state. When `ds`=1 at a clock edge, go to IDLE.
- Simultaneous `rd`=1 and `ds`=1 in DATA: `ds` wins and the state goes to IDLE. `rd` is evaluated fresh in IDLE on the next edge.
- Memory writes are accepted on any cycle in any state, including during reset deassertion.
- Write/read collision: `we` to `addr_q` on the same edge that enters DATA gives read-before-write, so `rdata` is the old word. A write to `addr_q` during WAIT (before that edge) is visible in `rdata`. Writes during DATA do not change `rdata`.
- All outputs are registered.

## Timing
- Reset values: state IDLE, `ws`=0, `rvalid`=0, `rdata`=0, `err`=0, counters 0. Memory contents are not reset.
- Reset asserted mid-transfer aborts immediately (asynchronously) to IDLE with reset values.
- `rd` sampled at edge E:
  - `ws`=1 during cycles E+1 .. E+WAIT_CYCLES.
  - `rvalid`=1 from cycle E+WAIT_CYCLES+1.
  - With WAIT_CYCLES=0, `rvalid`=1 at E+1 and `ws` never rises.
- `ds` sampled at edge F in DATA: `rvalid`=0 from cycle F+1. A new `rd` is sampled no earlier than edge F+1.
- Back-to-back minimum: WAIT_CYCLES+2 cycles per read (one DATA cycle, with `ds` arriving immediately).

## Configuration
- `READ_RESP_TIMEOUT_EN` defined: a DATA-state cycle counter is compiled in and cleared on DATA entry.
  - If TIMEOUT cycles elapse in DATA without `ds`, the state goes to IDLE.
  - `err`=1 for exactly the first IDLE cycle and `rvalid` drops in that same cycle.
  - `ds` on the same edge as expiry counts as normal completion, with no `err`.
- Not defined: no counter; DATA waits for `ds` indefinitely; `err` is tied 0. The port list is identical either way.

## Test plan
- Reset, write mem[3]=0xA5, pulse `rd` with `addr`=3, WAIT_CYCLES=2 -> `ws`=1 for exactly 2 cycles, then `rvalid`=1 with `rdata`=0xA5; `ds` one cycle later -> `rvalid`=0 next cycle.
- WAIT_CYCLES=0, mem[0]=0x3C, `rd` -> `rvalid`=1 the next cycle, `ws` stays 0 throughout.
- Hold `rd`=1 continuously through WAIT (initiator retry) -> wait count is not restarted; data appears at E+3; after `ds`, a second read starts from IDLE.
- Write 0x11 to `addr_q` during WAIT, then write 0x22 on the DATA-entry edge -> `rdata`=0x11; a later read of the same address returns 0x22.
- Assert `rst` during WAIT -> `ws`, `rvalid`, `rdata` are 0 immediately; after release the next `rd` behaves normally.
- With `READ_RESP_TIMEOUT_EN` and TIMEOUT=4, withhold `ds` -> exactly 4 `rvalid` cycles, then a 1-cycle `err` pulse and IDLE. Without the macro -> `rvalid` is held for 100 cycles and `err` stays 0.

Source files
------------

// File: rtl/read_responder_if.sv
// Read handshake bus between the initiator (master) and the memory-side read_responder (slave).
// Carries the rd/ws/ds read handshake plus the side write port that loads the responder memory.
interface read_responder_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) ();
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic              ds;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              ws;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              err;

  modport master (
    output rd, addr, ds, we, waddr, wdata,
    input  ws, rdata, rvalid, err
  );

  modport slave (
    input  rd, addr, ds, we, waddr, wdata,
    output ws, rdata, rvalid, err
  );
endinterface

// File: rtl/read_responder.sv
// Memory-side responder for the rd/ws/ds read handshake: wait states, then registered read data until ds.
// Optional DATA-state timeout with a one-cycle err pulse is compiled in with READ_RESP_TIMEOUT_EN.
module read_responder #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             rst,
  read_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMO_W = 8;

  if (WAIT_CYCLES > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("read_responder: WAIT_CYCLES must be 0..15 and TIMEOUT 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DATA
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ws_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_addr_d;
  logic [DATA_W-1:0] rdata_d;

  // With zero wait states the word is fetched on the same edge that samples rd
  assign rd_addr_d = (state_q == S_IDLE) ? bus.addr : addr_q;
  assign rdata_d   = mem[rd_addr_d];

  // Side write port; not reset and active in every state
  always_ff @(posedge clk) begin
    if (bus.we) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

`ifdef READ_RESP_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      ws_q     <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
`ifdef READ_RESP_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
`ifdef READ_RESP_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (bus.rd) begin
            addr_q <= bus.addr;
            cnt_q  <= CNT_W'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state_q  <= S_DATA;
              rvalid_q <= 1'b1;
              rdata_q  <= rdata_d;
`ifdef READ_RESP_TIMEOUT_EN
              tmo_q    <= '0;
`endif
            end else begin
              state_q <= S_WAIT;
              ws_q    <= 1'b1;
            end
          end
        end

        // Counter leaves WAIT on the edge where it would reach zero
        S_WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q  <= S_DATA;
            cnt_q    <= '0;
            ws_q     <= 1'b0;
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
`ifdef READ_RESP_TIMEOUT_EN
            tmo_q    <= '0;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        S_DATA: begin
          if (bus.ds) begin
            state_q  <= S_IDLE;
            rvalid_q <= 1'b0;
`ifdef READ_RESP_TIMEOUT_EN
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            state_q  <= S_IDLE;
            rvalid_q <= 1'b0;
            err_q    <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
`endif
          end
        end

        default: begin
          state_q  <= S_IDLE;
          ws_q     <= 1'b0;
          rvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ws     = ws_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
`ifdef READ_RESP_TIMEOUT_EN
  assign bus.err    = err_q;
`else
  assign bus.err    = 1'b0;
`endif

endmodule

// File: tb/tb_read_responder.sv
// Directed bench for read_responder: a WAIT_CYCLES=2 / TIMEOUT=4 instance and a zero-wait instance.
// Expectations follow the READ_RESP_TIMEOUT_EN setting of the build.
module tb_read_responder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  read_responder_if #(.ADDR_W(4), .DATA_W(8)) b2 ();
  read_responder_if #(.ADDR_W(4), .DATA_W(8)) b0 ();

  read_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(2), .TIMEOUT(4)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2.slave)
  );

  read_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(0), .TIMEOUT(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr2(input logic [3:0] a, input logic [7:0] d);
    b2.we = 1'b1; b2.waddr = a; b2.wdata = d;
    tick();
    b2.we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (b2.ws !== 1'b0) begin failures++; $display("FAIL reset_ws got=%b exp=0", b2.ws); end
    checks++; if (b2.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", b2.rvalid); end
    checks++; if (b2.rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", b2.rdata); end
    checks++; if (b2.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", b2.err); end
    checks++; if (b0.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid0 got=%b exp=0", b0.rvalid); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    wr2(4'd3, 8'hA5);
    b2.rd = 1'b1; b2.addr = 4'd3;
    tick();
    b2.rd = 1'b0;
    checks++; if (b2.ws !== 1'b1 || b2.rvalid !== 1'b0) begin failures++; $display("FAIL basic_e1 ws=%b rvalid=%b exp ws=1 rvalid=0", b2.ws, b2.rvalid); end
    tick();
    checks++; if (b2.ws !== 1'b1 || b2.rvalid !== 1'b0) begin failures++; $display("FAIL basic_e2 ws=%b rvalid=%b exp ws=1 rvalid=0", b2.ws, b2.rvalid); end
    tick();
    checks++; if (b2.ws !== 1'b0 || b2.rvalid !== 1'b1) begin failures++; $display("FAIL basic_e3 ws=%b rvalid=%b exp ws=0 rvalid=1", b2.ws, b2.rvalid); end
    checks++; if (b2.rdata !== 8'hA5) begin failures++; $display("FAIL basic_rdata got=%h exp=a5", b2.rdata); end
    b2.ds = 1'b1;
    tick();
    b2.ds = 1'b0;
    checks++; if (b2.rvalid !== 1'b0 || b2.ws !== 1'b0) begin failures++; $display("FAIL basic_done rvalid=%b ws=%b exp 0 0", b2.rvalid, b2.ws); end
  endtask

  task automatic test_zero_wait();
    b0.we = 1'b1; b0.waddr = 4'd0; b0.wdata = 8'h3C;
    tick();
    b0.we = 1'b0;
    b0.rd = 1'b1; b0.addr = 4'd0;
    tick();
    b0.rd = 1'b0;
    checks++; if (b0.rvalid !== 1'b1 || b0.ws !== 1'b0) begin failures++; $display("FAIL zw_e1 rvalid=%b ws=%b exp 1 0", b0.rvalid, b0.ws); end
    checks++; if (b0.rdata !== 8'h3C) begin failures++; $display("FAIL zw_rdata got=%h exp=3c", b0.rdata); end
    b0.ds = 1'b1;
    tick();
    b0.ds = 1'b0;
    checks++; if (b0.rvalid !== 1'b0 || b0.ws !== 1'b0) begin failures++; $display("FAIL zw_done rvalid=%b ws=%b exp 0 0", b0.rvalid, b0.ws); end
  endtask

  // rd held together with ds in DATA: ds wins, rd is sampled again from IDLE
  task automatic test_back_to_back();
    b0.rd = 1'b1; b0.addr = 4'd0;
    tick();
    checks++; if (b0.rvalid !== 1'b1) begin failures++; $display("FAIL b2b_first rvalid=%b exp=1", b0.rvalid); end
    b0.ds = 1'b1;
    tick();
    b0.ds = 1'b0;
    checks++; if (b0.rvalid !== 1'b0) begin failures++; $display("FAIL b2b_ds_wins rvalid=%b exp=0", b0.rvalid); end
    tick();
    b0.rd = 1'b0;
    checks++; if (b0.rvalid !== 1'b1 || b0.rdata !== 8'h3C) begin failures++; $display("FAIL b2b_second rvalid=%b rdata=%h exp 1 3c", b0.rvalid, b0.rdata); end
    b0.ds = 1'b1;
    tick();
    b0.ds = 1'b0;
    checks++; if (b0.rvalid !== 1'b0) begin failures++; $display("FAIL b2b_end rvalid=%b exp=0", b0.rvalid); end
  endtask

  task automatic test_rd_hold();
    wr2(4'd7, 8'h77);
    b2.rd = 1'b1; b2.addr = 4'd7;
    tick();
    b2.addr = 4'd3;
    checks++; if (b2.ws !== 1'b1) begin failures++; $display("FAIL hold_e1 ws=%b exp=1", b2.ws); end
    tick();
    checks++; if (b2.ws !== 1'b1 || b2.rvalid !== 1'b0) begin failures++; $display("FAIL hold_e2 ws=%b rvalid=%b exp 1 0", b2.ws, b2.rvalid); end
    tick();
    checks++; if (b2.rvalid !== 1'b1 || b2.ws !== 1'b0 || b2.rdata !== 8'h77) begin failures++; $display("FAIL hold_e3 rvalid=%b ws=%b rdata=%h exp 1 0 77", b2.rvalid, b2.ws, b2.rdata); end
    b2.rd = 1'b0; b2.ds = 1'b1;
    tick();
    b2.ds = 1'b0;
    checks++; if (b2.rvalid !== 1'b0) begin failures++; $display("FAIL hold_done rvalid=%b exp=0", b2.rvalid); end
    b2.rd = 1'b1; b2.addr = 4'd3;
    tick();
    b2.rd = 1'b0;
    tick();
    tick();
    checks++; if (b2.rvalid !== 1'b1 || b2.rdata !== 8'hA5) begin failures++; $display("FAIL hold_second rvalid=%b rdata=%h exp 1 a5", b2.rvalid, b2.rdata); end
    b2.ds = 1'b1;
    tick();
    b2.ds = 1'b0;
  endtask

  task automatic test_collision();
    wr2(4'd9, 8'h99);
    b2.rd = 1'b1; b2.addr = 4'd9;
    tick();
    b2.rd = 1'b0;
    b2.we = 1'b1; b2.waddr = 4'd9; b2.wdata = 8'h11;
    tick();
    b2.wdata = 8'h22;
    tick();
    b2.we = 1'b0;
    checks++; if (b2.rvalid !== 1'b1 || b2.rdata !== 8'h11) begin failures++; $display("FAIL coll_rbw rvalid=%b rdata=%h exp 1 11", b2.rvalid, b2.rdata); end
    b2.ds = 1'b1;
    tick();
    b2.ds = 1'b0;
    b2.rd = 1'b1; b2.addr = 4'd9;
    tick();
    b2.rd = 1'b0;
    tick();
    tick();
    checks++; if (b2.rvalid !== 1'b1 || b2.rdata !== 8'h22) begin failures++; $display("FAIL coll_reread rvalid=%b rdata=%h exp 1 22", b2.rvalid, b2.rdata); end
    wr2(4'd9, 8'h33);
    checks++; if (b2.rvalid !== 1'b1 || b2.rdata !== 8'h22) begin failures++; $display("FAIL coll_data_write rvalid=%b rdata=%h exp 1 22", b2.rvalid, b2.rdata); end
    b2.ds = 1'b1;
    tick();
    b2.ds = 1'b0;
  endtask

  task automatic test_reset_mid();
    b2.rd = 1'b1; b2.addr = 4'd3;
    tick();
    b2.rd = 1'b0;
    checks++; if (b2.ws !== 1'b1) begin failures++; $display("FAIL rstmid_pre ws=%b exp=1", b2.ws); end
    #1 rst = 1'b1;
    #1;
    checks++; if (b2.ws !== 1'b0 || b2.rvalid !== 1'b0 || b2.rdata !== 8'h00) begin failures++; $display("FAIL rstmid_async ws=%b rvalid=%b rdata=%h exp 0 0 00", b2.ws, b2.rvalid, b2.rdata); end
    tick();
    rst = 1'b0;
    tick();
    b2.rd = 1'b1; b2.addr = 4'd3;
    tick();
    b2.rd = 1'b0;
    checks++; if (b2.ws !== 1'b1) begin failures++; $display("FAIL rstmid_after_e1 ws=%b exp=1", b2.ws); end
    tick();
    tick();
    checks++; if (b2.rvalid !== 1'b1 || b2.rdata !== 8'hA5) begin failures++; $display("FAIL rstmid_after rvalid=%b rdata=%h exp 1 a5", b2.rvalid, b2.rdata); end
    b2.ds = 1'b1;
    tick();
    b2.ds = 1'b0;
  endtask

  task automatic test_timeout();
    b2.rd = 1'b1; b2.addr = 4'd3;
    tick();
    b2.rd = 1'b0;
    tick();
    tick();
`ifdef READ_RESP_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      checks++; if (b2.rvalid !== 1'b1 || b2.err !== 1'b0) begin failures++; $display("FAIL tmo_rvalid_c%0d rvalid=%b err=%b exp 1 0", i, b2.rvalid, b2.err); end
      if (i < 4) tick();
    end
    tick();
    checks++; if (b2.rvalid !== 1'b0 || b2.err !== 1'b1 || b2.ws !== 1'b0) begin failures++; $display("FAIL tmo_expire rvalid=%b err=%b ws=%b exp 0 1 0", b2.rvalid, b2.err, b2.ws); end
    tick();
    checks++; if (b2.err !== 1'b0 || b2.rvalid !== 1'b0) begin failures++; $display("FAIL tmo_pulse err=%b rvalid=%b exp 0 0", b2.err, b2.rvalid); end
    // ds on the expiry edge completes normally
    b2.rd = 1'b1; b2.addr = 4'd3;
    tick();
    b2.rd = 1'b0;
    tick();
    tick();
    tick();
    tick();
    tick();
    checks++; if (b2.rvalid !== 1'b1) begin failures++; $display("FAIL tmo_c4 rvalid=%b exp=1", b2.rvalid); end
    b2.ds = 1'b1;
    tick();
    b2.ds = 1'b0;
    checks++; if (b2.rvalid !== 1'b0 || b2.err !== 1'b0) begin failures++; $display("FAIL tmo_ds_wins rvalid=%b err=%b exp 0 0", b2.rvalid, b2.err); end
`else
    for (int i = 0; i < 100; i++) begin
      checks++; if (b2.rvalid !== 1'b1 || b2.err !== 1'b0 || b2.rdata !== 8'hA5) begin failures++; $display("FAIL notmo_hold_c%0d rvalid=%b err=%b rdata=%h exp 1 0 a5", i, b2.rvalid, b2.err, b2.rdata); end
      tick();
    end
    b2.ds = 1'b1;
    tick();
    b2.ds = 1'b0;
    checks++; if (b2.rvalid !== 1'b0 || b2.err !== 1'b0) begin failures++; $display("FAIL notmo_done rvalid=%b err=%b exp 0 0", b2.rvalid, b2.err); end
`endif
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    b2.rd = 1'b0; b2.addr = '0; b2.ds = 1'b0; b2.we = 1'b0; b2.waddr = '0; b2.wdata = '0;
    b0.rd = 1'b0; b0.addr = '0; b0.ds = 1'b0; b0.we = 1'b0; b0.waddr = '0; b0.wdata = '0;
    test_reset();
    test_basic();
    test_zero_wait();
    test_back_to_back();
    test_rd_hold();
    test_collision();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
